// File: rtl/adc_pkg.sv
// Shared types and default geometry for the SPI ADC sample sequencer.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET,
        WAIT
    } seq_state_t;

    localparam int SCK_DIV_DEF      = 4;
    localparam int FRAME_BITS_DEF   = 16;
    localparam int LEAD_BITS_DEF    = 4;
    localparam int DATA_BITS_DEF    = 12;
    localparam int QUIET_CYCLES_DEF = 4;

    // Shortest CS-fall to CS-fall spacing the frame timing allows.
    localparam int MIN_PERIOD = SCK_DIV_DEF / 2 + FRAME_BITS_DEF * SCK_DIV_DEF + QUIET_CYCLES_DEF;

    // Interval counter load value: counts down to zero on the cycle before the next CS fall.
    function automatic logic [15:0] ivl_load(input logic [15:0] ivl);
        return (ivl == 16'd0) ? 16'd0 : ivl - 16'd1;
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK divider: parks high when idle, first enabled cycles form the high half
// of the CS setup time, then runs low-half/high-half periods.
// rise: next cycle SCK goes high (SDO is sampled on this edge).
// wrap: last cycle of the current period.
// halt: stop at the end of this period and park SCK high.
module adc_sck_gen #(
    parameter int SCK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic halt,
    output logic sck,
    output logic rise,
    output logic wrap
);
    localparam int HALF = SCK_DIV / 2;
    localparam int PW   = $clog2(SCK_DIV);

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_nxt;

    assign rise = run && (ph == PW'(HALF - 1));
    assign wrap = run && (ph == PW'(SCK_DIV - 1));

    // Next phase: parked at the high-half start whenever not running.
    always_comb begin
        ph_nxt = PW'(HALF);
        if (run && !(wrap && halt))
            ph_nxt = wrap ? '0 : ph + PW'(1);
    end

    // Registered phase and SCK level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph  <= PW'(HALF);
            sck <= 1'b1;
        end else begin
            ph  <= ph_nxt;
            sck <= (ph_nxt >= PW'(HALF));
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Burst sequencer for a 12-bit SPI ADC with a one-entry output holding register.
// Build option: define ADC_SEQ_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module adc_sample_sequencer
    import adc_pkg::*;
#(
    parameter int SCK_DIV      = SCK_DIV_DEF,
    parameter int FRAME_BITS   = FRAME_BITS_DEF,
    parameter int LEAD_BITS    = LEAD_BITS_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          num_samples,
    input  logic [15:0]          interval,
    output logic                 busy,
    output logic                 done,
    output logic                 CS,
    output logic                 SCK,
    input  logic                 SDO,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun
`ifdef ADC_SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrun_cnt
`endif
);
    localparam int BW = $clog2(FRAME_BITS + 1);

    seq_state_t           state;
    logic [BW-1:0]        bitcnt;
    logic [7:0]           qcnt;
    logic [15:0]          ivl_cnt;
    logic [15:0]          ivl_l;
    logic [15:0]          num_l;
    logic [15:0]          conv_cnt;
    logic                 stop_pend;
    logic [DATA_BITS-1:0] cap;
    logic                 frame_end;

    logic sck_run, sck_halt, sck_rise, sck_wrap;
    logic start_acc, burst_end, data_bit;

    assign start_acc = (state == IDLE) && start && !stop;
    assign sck_run   = (state == SETUP) || (state == SHIFT);
    assign sck_halt  = (state == SHIFT) && (bitcnt == BW'(FRAME_BITS - 1));
    assign data_bit  = (bitcnt >= BW'(LEAD_BITS)) && (bitcnt < BW'(LEAD_BITS + DATA_BITS));
    assign burst_end = stop_pend || stop || ((num_l != 16'd0) && (conv_cnt == num_l));

    adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck (
        .clk  (clk),
        .rst  (rst),
        .run  (sck_run),
        .halt (sck_halt),
        .sck  (SCK),
        .rise (sck_rise),
        .wrap (sck_wrap)
    );

    // Sequencer FSM: frame timing, interval spacing, burst counting and stop handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            CS        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bitcnt    <= '0;
            qcnt      <= '0;
            ivl_cnt   <= '0;
            ivl_l     <= '0;
            num_l     <= '0;
            conv_cnt  <= '0;
            stop_pend <= 1'b0;
            cap       <= '0;
            frame_end <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_end <= 1'b0;
            if (ivl_cnt != 16'd0)
                ivl_cnt <= ivl_cnt - 16'd1;
            if (state != IDLE && stop)
                stop_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        num_l     <= num_samples;
                        ivl_l     <= interval;
                        ivl_cnt   <= ivl_load(interval);
                        conv_cnt  <= '0;
                        stop_pend <= 1'b0;
                        cap       <= '0;
                        busy      <= 1'b1;
                        CS        <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (sck_wrap) begin
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise && data_bit)
                        cap <= {cap[DATA_BITS-2:0], SDO};
                    if (sck_wrap) begin
                        if (sck_halt) begin
                            CS        <= 1'b1;
                            frame_end <= 1'b1;
                            conv_cnt  <= conv_cnt + 16'd1;
                            qcnt      <= '0;
                            state     <= QUIET;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                QUIET: begin
                    if (qcnt == 8'(QUIET_CYCLES - 1)) begin
                        if (burst_end) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (ivl_cnt == 16'd0) begin
                            // Interval already elapsed: run back-to-back at the minimum period.
                            CS      <= 1'b0;
                            ivl_cnt <= ivl_load(ivl_l);
                            state   <= SETUP;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        qcnt <= qcnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (ivl_cnt == 16'd0) begin
                        CS      <= 1'b0;
                        ivl_cnt <= ivl_load(ivl_l);
                        state   <= SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    // Saturating count of samples dropped because the holding register was full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overrun_cnt <= '0;
        else if (start_acc)
            overrun_cnt <= '0;
        else if (frame_end && sample_valid && !sample_ready && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif

    // One-entry holding register; drains independently of the sequencer state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (start_acc)
                overrun <= 1'b0;
            if (frame_end) begin
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end else begin
                    sample_data  <= cap;
                    sample_valid <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Controller that sequences repeated 12-bit conversions on the external SPI ADC, sharing the CS/SCK/SDO pins with no other block. Starts a burst on command, spaces conversions at a programmable interval, and hands each sample downstream over a valid/ready interface with a one-entry holding register. Sits between the ADC pins and the data collector, replacing free-running single-shot reads.

## Interface
- SCK_DIV, 4: clk cycles per SCK period; even, ≥2
- FRAME_BITS, 16: SCK periods per CS-low frame
- LEAD_BITS, 4: leading bits discarded before the MSB
- DATA_BITS, 12: sample width; LEAD_BITS+DATA_BITS ≤ FRAME_BITS
- QUIET_CYCLES, 4: minimum clk cycles CS stays high between frames
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin burst
- stop  in  1  one-cycle pulse: end burst after current frame
- num_samples  in  16  conversions per burst; 0 = continuous until stop
- interval  in  16  minimum clk cycles between CS falling edges
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when burst ends
- CS  out  1  ADC chip select, active-low
- SCK  out  1  ADC serial clock
- SDO  in  1  ADC serial data
- sample_data  out  DATA_BITS  captured sample, MSB first on wire
- sample_valid  out  1  sample_data valid
- sample_ready  in  1  downstream accepts when valid&&ready
- overrun  out  1  sticky: a sample was dropped; cleared by start

## Operation
- States: IDLE, SETUP, SHIFT, QUIET, WAIT.
- IDLE: CS=1, SCK=1. start (and not stop same cycle) → latch num_samples/interval, busy=1, clear overrun, → SETUP.
- SETUP: CS=0, SCK=1 for SCK_DIV/2 cycles, then → SHIFT. Interval counter loads interval on the CS-falling cycle.
- SHIFT: FRAME_BITS SCK periods; each period SCK low SCK_DIV/2 cycles then high SCK_DIV/2. SDO registered on the clk edge where SCK rises. Bits index LEAD_BITS..LEAD_BITS+DATA_BITS-1 shift into the capture register MSB first; others ignored. After last period → QUIET with CS=1, SCK=1.
- Frame end: capture register copied to sample_data, sample_valid=1, unless holding register still full (valid&&!ready on that cycle) → new sample dropped, overrun=1, holding register unchanged.
- QUIET: QUIET_CYCLES cycles. Then if burst complete (count reached, or stop pending) → IDLE, busy=0, done pulse; else → WAIT.
- WAIT: until interval counter expired, then → SETUP. Interval < minimum frame period → back-to-back at minimum period.
- stop: latched as pending in any busy state; current frame always completes; stop in IDLE ignored. start while busy ignored.
- Conversion counter 16-bit; continuous mode never terminates except by stop.
- sample_valid clears on valid&&ready; holding register independent of state (drains in IDLE).

## Timing
- Reset values: CS=1, SCK=1, sample_data=0, sample_valid=0, busy=0, done=0, overrun=0; state IDLE. Reset mid-frame forces these immediately (asynchronous).
- start at cycle 0 → CS low at cycle 1, first SCK fall at cycle 1+SCK_DIV/2.
- Defaults: CS low 2+64=66 cycles; sample_valid rises the cycle after CS rises; minimum CS-fall-to-CS-fall period 70 cycles.
- done asserts the cycle busy falls.

## Configuration
- ADC_SEQ_OVERRUN_CNT_EN defined: adds output overrun_cnt [7:0], counts dropped samples, saturates at 255, cleared by start and reset. Undefined: port absent, only sticky overrun flag.

## Structure
- Shared package adc_pkg: state enum, DATA_BITS/FRAME_BITS/LEAD_BITS defaults, MIN_PERIOD constant.
- One sub-module: adc_sck_gen (SCK divider with rise/fall strobes, enable from sequencer).

## Test plan
- num_samples=3, interval=100, ADC model returning 0xA5C, ready=1 → three frames, CS falls at cycles 1/101/201, three samples 0xA5C, done once, busy low after.
- Leading bits driven 1, data 0x001 → sample_data=0x001 (lead bits discarded).
- interval=10 (< 70), num_samples=2 → second CS fall at cycle 71.
- ready=0, num_samples=3 → first sample held, samples 2-3 dropped, overrun=1; with macro overrun_cnt=2.
- num_samples=0, stop mid-SHIFT of frame 5 → frame 5 delivered, IDLE, done pulse, no sixth CS fall.
- rst low mid-SHIFT → CS=1, SCK=1, valid=0 same cycle; next start runs full clean frame.
